// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: RV32 load/store size codes and FSM states.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads, plus the
// misalign/illegal-size error flag. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [31:0] shifted_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [3:0]  be_c;
    logic [31:0] ext_c;
    logic        err_c;

    always_comb begin
        shifted_c = rdword_i >> {addr_lo_i, 3'b000};
        byte_c    = shifted_c[7:0];
        half_c    = shifted_c[15:0];
        be_c      = '0;
        wword_o   = '0;
        ext_c     = '0;
        err_c     = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_c    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                ext_c   = {{24{byte_c[7]}}, byte_c};
            end
            F3_H: begin
                err_c   = addr_lo_i[0];
                be_c    = 4'b0011 << addr_lo_i;
                wword_o = {2{wdata_i[15:0]}};
                ext_c   = {{16{half_c[15]}}, half_c};
            end
            F3_W: begin
                err_c   = (addr_lo_i != 2'b00);
                be_c    = 4'b1111;
                wword_o = wdata_i;
                ext_c   = rdword_i;
            end
            // Unsigned sizes exist only for loads.
            F3_BU: begin
                err_c = we_i;
                ext_c = {24'b0, byte_c};
            end
            F3_HU: begin
                err_c = we_i | addr_lo_i[0];
                ext_c = {16'b0, half_c};
            end
            default: err_c = 1'b1;
        endcase
        be_o    = (we_i && !err_c) ? be_c : 4'b0000;
        rdata_o = (we_i || err_c) ? 32'b0 : ext_c;
        err_o   = err_c;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the MEM-stage load/store port: accepts one request,
// waits WAIT_CYCLES, commits the store or returns the load as a one-cycle response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture_c;
    logic              commit_c;

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [2:0]        req_funct3_q;

    logic              ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              cur_we_c;
    logic [ADDR_W-1:0] cur_addr_c;
    logic [DATA_W-1:0] cur_wdata_c;
    logic [2:0]        cur_funct3_c;
    logic [IDX_W-1:0]  word_idx_c;
    logic [DATA_W-1:0] rdword_c;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wword_c;
    logic [DATA_W-1:0] ext_rdata_c;
    logic              err_c;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        commit_c = (state_d == RESP);
    end

    // With zero wait states the commit edge is also the accept edge, so use live inputs.
    always_comb begin
        cur_we_c     = (state_q == IDLE) ? req_we     : req_we_q;
        cur_addr_c   = (state_q == IDLE) ? req_addr   : req_addr_q;
        cur_wdata_c  = (state_q == IDLE) ? req_wdata  : req_wdata_q;
        cur_funct3_c = (state_q == IDLE) ? req_funct3 : req_funct3_q;
        word_idx_c   = cur_addr_c[ADDR_W-1:2];
        rdword_c     = mem_q[word_idx_c];
    end

    dmem_lane_align u_align (
        .we_i     (cur_we_c),
        .funct3_i (cur_funct3_c),
        .addr_lo_i(cur_addr_c[1:0]),
        .wdata_i  (cur_wdata_c),
        .rdword_i (rdword_c),
        .be_o     (be_c),
        .wword_o  (wword_c),
        .rdata_o  (ext_rdata_c),
        .err_o    (err_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= (state_d == IDLE);
            rsp_valid_q <= commit_c;
            rsp_rdata_q <= commit_c ? ext_rdata_c : '0;
            rsp_err_q   <= commit_c && err_c;
        end
    end

    always_ff @(posedge clk) begin
        if (capture_c) begin
            req_we_q     <= req_we;
            req_addr_q   <= req_addr;
            req_wdata_q  <= req_wdata;
            req_funct3_q <= req_funct3;
        end
    end

    // Array is never reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem_q[word_idx_c][8*i +: 8] <= wword_c[8*i +: 8];
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-addressed reference memory, directed
// scenarios followed by randomized traffic, plus a zero-wait-state instance.
module tb_dmem_responder;

    localparam int unsigned W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req0_valid, req0_ready, req0_we;
    logic [8:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic [2:0]  req0_funct3;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req0_valid), .req_ready(req0_ready), .req_we(req0_we),
        .req_addr(req0_addr), .req_wdata(req0_wdata), .req_funct3(req0_funct3),
        .rsp_valid(rsp0_valid), .rsp_rdata(rsp0_rdata), .rsp_err(rsp0_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [512];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         busy_until = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed little-endian memory, size/alignment rules applied directly.
    task automatic model(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output logic err);
        int          size;
        bit          uns;
        bit          legal;
        logic [31:0] val;
        size  = 1;
        uns   = 1'b0;
        legal = 1'b1;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1'b1; legal = !we; end
            3'd5: begin size = 2; uns = 1'b1; legal = !we; end
            default: legal = 1'b0;
        endcase
        err = !legal || ((int'(addr) % size) != 0);
        rd  = '0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) mem_m[int'(addr) + k] = wdata[8*k +: 8];
            end else begin
                val = '0;
                for (int k = 0; k < size; k++) val = val | (32'(mem_m[int'(addr) + k]) << (8*k));
                if (!uns && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
                rd = val;
            end
        end
    endtask

    // One cycle of driving, entered and left at a negedge.
    task automatic step(input bit v, input bit track, input logic we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, output bit acc);
        logic exp_ready;
        exp_t e;
        exp_ready = (cyc > busy_until);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        req_valid  = v;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        acc = v && exp_ready;
        if (acc) begin
            busy_until = cyc + W + 1;
            if (track) begin
                model(we, addr, wdata, f3, e.rdata, e.err);
                e.due = cyc + W + 1;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input bit track, input logic we, input logic [8:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        bit acc;
        acc = 1'b0;
        while (!acc) step(1'b1, track, we, addr, wdata, f3, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'd0, acc);
    endtask

    // Monitor: exactly one response per tracked request, at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                chk("rsp_rdata_idle", rsp_rdata, 32'd0);
                chk("rsp_err_idle", 32'(rsp_err), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bit acc;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0; req0_funct3 = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        chk("reset_ready0", 32'(req0_ready), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 128; i++) issue(1'b1, 1'b1, 9'(i * 4), $urandom, 3'd2);

        issue(1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'd2);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        issue(1'b1, 1'b1, 9'h011, 32'h0000_0080, 3'd0);
        issue(1'b1, 1'b0, 9'h011, 32'h0, 3'd0);
        issue(1'b1, 1'b0, 9'h011, 32'h0, 3'd4);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        issue(1'b1, 1'b1, 9'h013, 32'h0000_1234, 3'd1);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
        issue(1'b1, 1'b0, 9'h012, 32'h0, 3'd5);
        idle(3);

        // Valid held high: accepts only when the block has returned to IDLE.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 9'h010, $urandom, 3'd2, acc);
        idle(4);

        // Reset during wait states drops the store.
        issue(1'b0, 1'b1, 9'h020, 32'h0000_0055, 3'd2);
        reset = 1'b1;
        req_valid = 1'b0;
        chk("ready_in_wait", 32'(req_ready), 32'd0);
        busy_until = cyc;
        @(negedge clk);
        reset = 1'b0;
        issue(1'b1, 1'b0, 9'h020, 32'h0, 3'd2);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            logic [8:0] a;
            a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue(1'b1, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
        end
        idle(W + 3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Zero-wait-state instance: SW then LW with valid held high.
        chk("w0_ready_k0", 32'(req0_ready), 32'd1);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h010;
        req0_wdata = 32'hCAFE_F00D; req0_funct3 = 3'd2;
        @(negedge clk);
        chk("w0_ready_k1", 32'(req0_ready), 32'd0);
        chk("w0_rsp_k1", 32'(rsp0_valid), 32'd1);
        chk("w0_rdata_k1", rsp0_rdata, 32'd0);
        chk("w0_err_k1", 32'(rsp0_err), 32'd0);
        req0_we = 1'b0;
        @(negedge clk);
        chk("w0_ready_k2", 32'(req0_ready), 32'd1);
        chk("w0_rsp_k2", 32'(rsp0_valid), 32'd0);
        @(negedge clk);
        chk("w0_ready_k3", 32'(req0_ready), 32'd0);
        chk("w0_rsp_k3", 32'(rsp0_valid), 32'd1);
        chk("w0_rdata_k3", rsp0_rdata, 32'hCAFE_F00D);
        chk("w0_err_k3", 32'(rsp0_err), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("w0_ready_k4", 32'(req0_ready), 32'd1);
        chk("w0_rsp_k4", 32'(rsp0_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
